// File: rtl/phy_tx_lanes_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// phy_tx_lanes_if : word-input valid/ready handshake for phy_tx_lanes
// Revision 1.0
// ---------------------------------------------------------------------------
interface phy_tx_lanes_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/phy_tx_lanes.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// phy_tx_lanes : round-robin striping of words onto NUM_LANES serial lanes
// Revision 1.0
// ---------------------------------------------------------------------------
module phy_tx_lanes #(
  parameter int               NUM_LANES  = 2,
  parameter int               WORD_W     = 32,
  parameter int               SYM_W      = 8,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [SYM_W-1:0] IDLE_SYM   = 8'hBC
) (
  input  logic                 clk,
  input  logic                 reset,
  phy_tx_lanes_if.slave        in_if,
  output logic [NUM_LANES-1:0] serial_o,
  output logic [NUM_LANES-1:0] lane_active,
  output logic                 frame_sync
);

  localparam int                CNT_W      = $clog2(WORD_W);
  localparam int                RR_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                LVL_W      = PTR_W + 1;
  localparam logic [WORD_W-1:0] IDLE_FRAME = {(WORD_W / SYM_W){IDLE_SYM}};

  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0] full;
  logic                 load;
  logic                 accept;

  assign load           = (bit_cnt_q == CNT_W'(WORD_W - 1));
  // Ready looks only at registered state so it never depends on in_valid.
  assign in_if.in_ready = !reset && !full[rr_ptr_q];
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign frame_sync     = !reset && (bit_cnt_q == '0);

  always_comb begin
    bit_cnt_d = load ? '0 : bit_cnt_q + CNT_W'(1);
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (rr_ptr_q == RR_W'(NUM_LANES - 1)) ? '0 : rr_ptr_q + RR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q;
    logic [PTR_W-1:0]  rd_q;
    logic [LVL_W-1:0]  lvl_q;
    logic [WORD_W-1:0] shreg_q;
    logic              act_q;
    logic              push;
    logic              pop;

    assign push    = accept && (rr_ptr_q == RR_W'(i));
    // The load decision uses the pre-edge level, so a same-edge push is not seen.
    assign pop     = load && (lvl_q != '0);
    assign full[i] = (lvl_q == LVL_W'(FIFO_DEPTH));

    assign serial_o[i]    = reset ? IDLE_SYM[SYM_W-1] : shreg_q[WORD_W-1];
    assign lane_active[i] = act_q;

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_q] <= in_if.in_data;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_q    <= '0;
        rd_q    <= '0;
        lvl_q   <= '0;
        shreg_q <= IDLE_FRAME;
        act_q   <= 1'b0;
      end else begin
        if (push) begin
          wr_q <= wr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_q <= rd_q + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   lvl_q <= lvl_q + LVL_W'(1);
          2'b01:   lvl_q <= lvl_q - LVL_W'(1);
          default: lvl_q <= lvl_q;
        endcase
        if (load) begin
          shreg_q <= pop ? mem_q[rd_q] : IDLE_FRAME;
          act_q   <= pop;
        end else begin
          shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule
`default_nettype wire
